frame_buffer: RTL

FRAME_BUFFER -- requirements
Module: frame_buffer

---
 rtl/frame_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/frame_buffer.sv
// frame_buffer -- double-buffered 8x16 monochrome frame store.
//
// Two 8-row by 16-pixel buffers. Rows are written into the back buffer
// with a per-pixel mask, while the front buffer drives the registered
// frame output. A swap request waits until the downstream scanner reaches
// the last row, so the display never shows a torn frame. A clear request
// zeroes the back buffer one row per cycle.
//
// Optional build macro: FB_AUTOCLEAR_EN. When defined, every swap is
// followed by an automatic clear of the new back buffer. When undefined,
// the new back buffer keeps the contents of the previous front buffer.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   wr_en      row-write strobe (accepted only while ready)
//   wr_row     target back-buffer row
//   wr_data    pixel data, bit 15 = leftmost column
//   wr_mask    per-pixel write enable
//   clr        request to clear the back buffer
//   swap_req   request to swap front and back buffers
//   scan_row   row currently driven by the downstream scanner
//   ready      high when writes, clr and swap_req are accepted
//   swap_done  one-cycle pulse after a swap
//   frame      front buffer contents, row r at [127-16r : 112-16r]
module frame_buffer #(
    parameter int ROWS = 8,
    parameter int COLS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [COLS-1:0]          wr_data,
    input  logic [COLS-1:0]          wr_mask,
    input  logic                     clr,
    input  logic                     swap_req,
    input  logic [7:0]               scan_row,
    output logic                     ready,
    output logic                     swap_done,
    output logic [ROWS*COLS-1:0]     frame
);

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [7:0]    LAST_SCAN = 8'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        CLEARING
    } state_t;

    state_t              state;
    logic                front_sel;   // 0: buf_a is front, 1: buf_b is front
    logic [RW-1:0]       clr_row;
    logic [COLS-1:0]     buf_a [ROWS];
    logic [COLS-1:0]     buf_b [ROWS];
    logic [ROWS*COLS-1:0] front_flat;

    function automatic logic [COLS-1:0] merge_px(
        input logic [COLS-1:0] old_px,
        input logic [COLS-1:0] new_px,
        input logic [COLS-1:0] mask
    );
        return (old_px & ~mask) | (new_px & mask);
    endfunction

    assign ready = (state == IDLE);

    // Row 0 lands in the most significant slice of the flat frame.
    always_comb begin
        front_flat = '0;
        for (int r = 0; r < ROWS; r++) begin
            front_flat[(ROWS-1-r)*COLS +: COLS] = front_sel ? buf_b[r] : buf_a[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_a     <= '{default: '0};
            buf_b     <= '{default: '0};
            front_sel <= 1'b0;
            state     <= IDLE;
            clr_row   <= '0;
            swap_done <= 1'b0;
            frame     <= '0;
        end else begin
            // frame trails the front buffer by one cycle.
            frame     <= front_flat;
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A write in the same cycle as swap_req/clr still lands
                    // before the state change.
                    if (wr_en) begin
                        if (front_sel)
                            buf_a[wr_row] <= merge_px(buf_a[wr_row], wr_data, wr_mask);
                        else
                            buf_b[wr_row] <= merge_px(buf_b[wr_row], wr_data, wr_mask);
                    end
                    if (swap_req) begin
                        state <= PENDING;
                    end else if (clr) begin
                        state   <= CLEARING;
                        clr_row <= '0;
                    end
                end
                PENDING: begin
                    // Swap only once the scanner is on the last row; any
                    // other value (including out-of-range ones) just waits.
                    if (scan_row == LAST_SCAN) begin
                        front_sel <= ~front_sel;
                        swap_done <= 1'b1;
`ifdef FB_AUTOCLEAR_EN
                        state     <= CLEARING;
                        clr_row   <= '0;
`else
                        state     <= IDLE;
`endif
                    end
                end
                CLEARING: begin
                    if (front_sel)
                        buf_a[clr_row] <= '0;
                    else
                        buf_b[clr_row] <= '0;
                    clr_row <= clr_row + 1'b1;
                    if (clr_row == LAST_ROW)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
